csr_bus_arbiter: RTL and testbench

//   Shares one CSR strobe/data bus (csr_data_o, csr_stb_o, concatenated csr_data_i) between
//   NUM_MASTERS requesters, e.g. host GPIO bridge and packet-based remote access. Round-robin

---
 rtl/csr_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_csr_bus_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/csr_bus_arbiter.sv
// Round-robin arbiter sharing one CSR strobe/data bus between NUM_MASTERS requesters.
// One access in flight: IDLE -> STROBE -> ACK -> IDLE, all outputs registered.
module csr_bus_arbiter #(
  parameter int NUM_MASTERS          = 2,
  parameter int CSR_DATA_BUS_WIDTH   = 32,
  parameter int CSR_STROBE_BUS_WIDTH = 32,
  localparam int SEL_W = (CSR_STROBE_BUS_WIDTH > 1) ? $clog2(CSR_STROBE_BUS_WIDTH) : 1,
  localparam int DW    = CSR_DATA_BUS_WIDTH,
  localparam int SW    = CSR_STROBE_BUS_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_MASTERS-1:0]       req_i,
  input  logic [NUM_MASTERS-1:0]       we_i,
  input  logic [NUM_MASTERS*SEL_W-1:0] sel_i,
  input  logic [NUM_MASTERS*DW-1:0]    wdata_i,
  output logic [NUM_MASTERS-1:0]       ack_o,
  output logic [DW-1:0]                rdata_o,
  output logic                         busy_o,
  output logic [DW-1:0]                csr_data_o,
  output logic [SW-1:0]                csr_stb_o,
  input  logic [DW*SW-1:0]             csr_data_i
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STROBE = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;

  logic [1:0]             r_state;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       r_grant;
  logic [SEL_W-1:0]       r_sel;
  logic [NUM_MASTERS-1:0] r_ack;
  logic [DW-1:0]          r_rdata;
  logic                   r_busy;
  logic [DW-1:0]          r_csr_data;
  logic [SW-1:0]          r_csr_stb;

  logic                   w_found;
  logic [PTR_W-1:0]       w_gidx;
  logic [PTR_W-1:0]       w_ptr_nxt;
  logic                   w_we;
  logic [SEL_W-1:0]       w_sel;
  logic [DW-1:0]          w_wdata;
  logic [SW-1:0]          w_stb;
  logic [DW-1:0]          w_rd;
  logic [NUM_MASTERS-1:0] w_ack;

  // Rotating priority: first pass covers [ptr, N-1], second pass wraps to [0, ptr-1].
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!w_found && req_i[i] && (PTR_W'(i) >= r_ptr)) begin
        w_found = 1'b1;
        w_gidx  = PTR_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!w_found && req_i[i]) begin
        w_found = 1'b1;
        w_gidx  = PTR_W'(i);
      end
    end
  end

  assign w_ptr_nxt = (w_gidx == PTR_W'(NUM_MASTERS - 1)) ? '0 : w_gidx + 1'b1;

  always_comb begin
    w_we    = 1'b0;
    w_sel   = '0;
    w_wdata = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (PTR_W'(i) == w_gidx) begin
        w_we    = we_i[i];
        w_sel   = sel_i[i*SEL_W +: SEL_W];
        w_wdata = wdata_i[i*DW +: DW];
      end
    end
  end

  // Out-of-range selects match no strobe bit and read back as zero.
  always_comb begin
    w_stb = '0;
    w_rd  = '0;
    for (int unsigned j = 0; j < SW; j++) begin
      w_stb[j] = w_we && (w_sel == SEL_W'(j));
      if (r_sel == SEL_W'(j)) begin
        w_rd = csr_data_i[j*DW +: DW];
      end
    end
  end

  always_comb begin
    w_ack = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      w_ack[i] = (r_grant == PTR_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_sel      <= '0;
      r_ack      <= '0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
      r_csr_data <= '0;
      r_csr_stb  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state   <= STROBE;
            r_busy    <= 1'b1;
            r_grant   <= w_gidx;
            r_sel     <= w_sel;
            r_ptr     <= w_ptr_nxt;
            r_csr_stb <= w_stb;
            if (w_we) begin
              r_csr_data <= w_wdata;
            end
          end
        end
        STROBE: begin
          r_state   <= ACK;
          r_csr_stb <= '0;
          r_ack     <= w_ack;
          r_rdata   <= w_rd;
        end
        ACK: begin
          r_state <= IDLE;
          r_ack   <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_ack     <= '0;
          r_busy    <= 1'b0;
          r_csr_stb <= '0;
        end
      endcase
    end
  end

  assign ack_o      = r_ack;
  assign rdata_o    = r_rdata;
  assign busy_o     = r_busy;
  assign csr_data_o = r_csr_data;
  assign csr_stb_o  = r_csr_stb;

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Directed bench for csr_bus_arbiter: default 2x32x32 instance plus a 24-register instance
// for out-of-range select behaviour.
module tb_csr_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default instance: 2 masters, DW=32, SW=32, SEL_W=5
  logic [1:0]      req, we, ack;
  logic [9:0]      sel;
  logic [63:0]     wdata;
  logic [31:0]     rdata, cdata;
  logic            busy;
  logic [31:0]     stb;
  logic [32*32-1:0] cin;

  csr_bus_arbiter #(.NUM_MASTERS(2), .CSR_DATA_BUS_WIDTH(32), .CSR_STROBE_BUS_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .sel_i(sel), .wdata_i(wdata),
    .ack_o(ack), .rdata_o(rdata), .busy_o(busy), .csr_data_o(cdata), .csr_stb_o(stb),
    .csr_data_i(cin));

  // Second instance: SW=24 so selects 24..31 are out of range
  logic [1:0]       req2, we2, ack2;
  logic [9:0]       sel2;
  logic [63:0]      wdata2;
  logic [31:0]      rdata2, cdata2;
  logic             busy2;
  logic [23:0]      stb2;
  logic [32*24-1:0] cin2;

  csr_bus_arbiter #(.NUM_MASTERS(2), .CSR_DATA_BUS_WIDTH(32), .CSR_STROBE_BUS_WIDTH(24)) u_dut24 (
    .clk(clk), .rst(rst), .req_i(req2), .we_i(we2), .sel_i(sel2), .wdata_i(wdata2),
    .ack_o(ack2), .rdata_o(rdata2), .busy_o(busy2), .csr_data_o(cdata2), .csr_stb_o(stb2),
    .csr_data_i(cin2));

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    req = '0; we = '0; sel = '0; wdata = '0;
    req2 = '0; we2 = '0; sel2 = '0; wdata2 = '0;
    for (int i = 0; i < 32; i++) cin[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 24; i++) cin2[i*32 +: 32] = 32'hB000_0000 + 32'(i);

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_stb", 64'(stb), 64'h0);
    chk("rst_data", 64'(cdata), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    tick();
    tick();
    rst = 1'b0;

    // 1: m0 write sel=5
    req = 2'b01; we = 2'b01; sel[4:0] = 5'd5; wdata[31:0] = 32'hDEAD_BEEF;
    tick();
    chk("t1_stb", 64'(stb), 64'h20);
    chk("t1_data", 64'(cdata), 64'hDEAD_BEEF);
    chk("t1_busy", 64'(busy), 64'h1);
    chk("t1_noack", 64'(ack), 64'h0);
    tick();
    chk("t1_ack", 64'(ack), 64'h1);
    chk("t1_stb_off", 64'(stb), 64'h0);
    chk("t1_readback", 64'(rdata), 64'hA000_0005);
    req = 2'b00;
    tick();
    chk("t1_ack_off", 64'(ack), 64'h0);
    chk("t1_idle_busy", 64'(busy), 64'h0);
    chk("t1_data_hold", 64'(cdata), 64'hDEAD_BEEF);
    tick();
    chk("t1_still_idle", 64'(busy), 64'h0);
    chk("t1_rdata_hold", 64'(rdata), 64'hA000_0005);

    // 2: m1 read sel=3 of 0x12345678
    cin[3*32 +: 32] = 32'h1234_5678;
    req = 2'b10; we = 2'b00; sel[9:5] = 5'd3;
    tick();
    chk("t2_stb", 64'(stb), 64'h0);
    chk("t2_busy", 64'(busy), 64'h1);
    tick();
    chk("t2_ack", 64'(ack), 64'h2);
    chk("t2_rdata", 64'(rdata), 64'h1234_5678);
    chk("t2_data", 64'(cdata), 64'hDEAD_BEEF);
    req = 2'b00;
    tick();

    // 3: both request continuously from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 2'b11; we = 2'b00; sel[4:0] = 5'd1; sel[9:5] = 5'd2;
    for (int k = 0; k < 4; k++) begin
      chk("t3_idle_busy", 64'(busy), 64'h0);
      chk("t3_idle_ack", 64'(ack), 64'h0);
      tick();
      chk("t3_strobe_busy", 64'(busy), 64'h1);
      chk("t3_strobe_ack", 64'(ack), 64'h0);
      tick();
      chk("t3_ack", 64'(ack), (k % 2 == 0) ? 64'h1 : 64'h2);
      chk("t3_rdata", 64'(rdata), (k % 2 == 0) ? 64'hA000_0001 : 64'hA000_0002);
      chk("t3_ack_busy", 64'(busy), 64'h1);
      tick();
    end

    // 4: async reset during STROBE of an m1 write
    req = 2'b10; we = 2'b10; sel[9:5] = 5'd7; wdata[63:32] = 32'h55AA_55AA;
    tick();
    chk("t4_stb", 64'(stb), 64'h80);
    chk("t4_busy", 64'(busy), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_stb", 64'(stb), 64'h0);
    chk("t4_rst_busy", 64'(busy), 64'h0);
    chk("t4_rst_ack", 64'(ack), 64'h0);
    chk("t4_rst_data", 64'(cdata), 64'h0);
    tick();
    rst = 1'b0;
    req = 2'b11; we = 2'b00; sel[4:0] = 5'd1; sel[9:5] = 5'd2;
    chk("t4_no_stale_ack", 64'(ack), 64'h0);
    tick();
    chk("t4_no_stale_ack2", 64'(ack), 64'h0);
    tick();
    chk("t4_m0_first", 64'(ack), 64'h1);
    chk("t4_rdata", 64'(rdata), 64'hA000_0001);

    // 6: m1 drops req during STROBE (pointer now 1)
    tick();
    chk("t6_idle", 64'(busy), 64'h0);
    tick();
    req = 2'b01;
    tick();
    chk("t6_m1_ack", 64'(ack), 64'h2);
    chk("t6_m1_rdata", 64'(rdata), 64'hA000_0002);
    tick();
    tick();
    tick();
    chk("t6_m0_ack", 64'(ack), 64'h1);
    chk("t6_m0_rdata", 64'(rdata), 64'hA000_0001);
    req = 2'b00;
    tick();
    tick();
    chk("t6_no_regrant_busy", 64'(busy), 64'h0);
    chk("t6_no_regrant_ack", 64'(ack), 64'h0);

    // 5: SW=24 instance, out-of-range select 30
    req2 = 2'b01; we2 = 2'b00; sel2[4:0] = 5'd4;
    tick();
    tick();
    chk("t5_pre_rdata", 64'(rdata2), 64'hB000_0004);
    req2 = 2'b00;
    tick();
    req2 = 2'b01; we2 = 2'b01; sel2[4:0] = 5'd30; wdata2[31:0] = 32'h1111_1111;
    tick();
    chk("t5_w_stb", 64'(stb2), 64'h0);
    chk("t5_w_busy", 64'(busy2), 64'h1);
    tick();
    chk("t5_w_ack", 64'(ack2), 64'h1);
    chk("t5_w_rdata", 64'(rdata2), 64'h0);
    req2 = 2'b00;
    tick();
    req2 = 2'b01; we2 = 2'b00;
    tick();
    chk("t5_r_stb", 64'(stb2), 64'h0);
    tick();
    chk("t5_r_ack", 64'(ack2), 64'h1);
    chk("t5_r_rdata", 64'(rdata2), 64'h0);
    req2 = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
